// File: rtl/ped_pkg.sv
// ped_pkg: state encoding and shared constants for the
// pedestrian walk controller (ped_walk_ctrl, sec_tick_gen).
package ped_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    FLASH = 3'd2,
    CLEAR = 3'd3,
    FAULT = 3'd4
  } ped_state_e;

  localparam int unsigned DEF_CLK_PER_SEC = 50000000;

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: free-running 1 s prescaler with a half-second
// tick; clr restarts the second so a walk begins on a boundary.
module sec_tick_gen
  import ped_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = DEF_CLK_PER_SEC
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic sec_tick,
  output logic half_tick
);

  localparam int unsigned W = $clog2(CLK_PER_SEC);
  localparam logic [W-1:0] TERM = W'(CLK_PER_SEC - 1);
  localparam logic [W-1:0] HALF = W'(CLK_PER_SEC / 2 - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sec_tick  = (cnt_q == TERM);
  assign half_tick = sec_tick | (cnt_q == HALF);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clr || sec_tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ped_walk_ctrl.sv
// ped_walk_ctrl: pedestrian WALK/DON'T-WALK stage behind gry_light.
// Define PED_BEEP_EN to add the registered audible beep output.
module ped_walk_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int unsigned WALK_SEC    = 10,
  parameter int unsigned FLASH_SEC   = 5,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             green,
  input  logic             yellow,
  input  logic             red,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             fault
`ifdef PED_BEEP_EN
  ,
  output logic             beep
`endif
);

  localparam logic [CNT_W-1:0] CD_FULL  = CNT_W'(WALK_SEC + FLASH_SEC);
  localparam logic [CNT_W-1:0] CD_FLASH = CNT_W'(FLASH_SEC);
  localparam logic [CNT_W-1:0] CD_ONE   = CNT_W'(1);

  ped_state_e       state_q, state_d;
  logic             red_q;
  logic             walk_q, walk_d;
  logic             dw_q, dw_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic             req_q, req_d;
  logic             fault_q, fault_d;
  logic             clr;
  logic             sec_tick, half_tick;
  logic             red_rise, lights_ok;

  assign red_rise  = red & ~red_q;
  assign lights_ok = $onehot({green, yellow, red});

  sec_tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .sec_tick (sec_tick),
    .half_tick(half_tick)
  );

  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    dw_d    = dw_q;
    cd_d    = cd_q;
    req_d   = req_q;
    fault_d = fault_q;
    clr     = 1'b0;
    if (!lights_ok || state_q == FAULT) begin
      state_d = FAULT;
      fault_d = 1'b1;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      cd_d    = '0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ped_btn) req_d = 1'b1;
          if (red_rise && (req_q || ped_btn)) begin
            state_d = WALK;
            walk_d  = 1'b1;
            dw_d    = 1'b0;
            cd_d    = CD_FULL;
            req_d   = 1'b0;
            clr     = 1'b1;
          end
        end
        WALK: begin
          if (!red) begin
            state_d = CLEAR;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            cd_d    = '0;
          end else if (sec_tick) begin
            cd_d = cd_q - CD_ONE;
            if (cd_d == CD_FLASH) begin
              state_d = FLASH;
              walk_d  = 1'b0;
              dw_d    = 1'b1;
            end
          end
        end
        FLASH: begin
          if (ped_btn) req_d = 1'b1;
          if (!red) begin
            state_d = CLEAR;
            dw_d    = 1'b1;
            cd_d    = '0;
          end else begin
            if (half_tick) dw_d = ~dw_q;
            if (sec_tick) cd_d = cd_q - CD_ONE;
            // the final toggle coincides with the last tick
            if (sec_tick && cd_d == '0) begin
              state_d = CLEAR;
              dw_d    = 1'b1;
            end
          end
        end
        CLEAR: begin
          if (ped_btn) req_d = 1'b1;
          if (!red) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      red_q   <= 1'b0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      cd_q    <= '0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      red_q   <= red;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      cd_q    <= cd_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dw_q;
  assign countdown   = cd_q;
  assign req_pending = req_q;
  assign fault       = fault_q;

`ifdef PED_BEEP_EN
  logic beep_q, beep_d;

  // prescaler restarts on WALK entry, so the first half is high
  always_comb begin
    beep_d = 1'b0;
    if (state_d == WALK)
      beep_d = (state_q == WALK) ? (beep_q ^ half_tick) : 1'b1;
    else if (state_d == FLASH)
      beep_d = dw_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) beep_q <= 1'b0;
    else       beep_q <= beep_d;
  end

  assign beep = beep_q;
`endif

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// tb_ped_walk_ctrl: randomized light/button traffic for ped_walk_ctrl,
// scored against a time-since-grant model (beep when PED_BEEP_EN).
`timescale 1ns/1ps
module tb_ped_walk_ctrl;

  localparam int CPS = 10;
  localparam int WS  = 3;
  localparam int FS  = 2;
  localparam int CW  = 8;
  localparam int WALK_CYC = WS * CPS;
  localparam int TOT_CYC  = (WS + FS) * CPS;

  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_CLR  = 2;
  localparam int M_FLT  = 3;

  typedef struct {
    int          cyc;
    logic        walk;
    logic        dw;
    logic [CW-1:0] cd;
    logic        req;
    logic        flt;
    logic        bp;
  } exp_t;

  logic clk, rstn, green, yellow, red, ped_btn;
  logic walk, dont_walk, req_pending, fault;
  logic [CW-1:0] countdown;
  logic beep_got;

  ped_walk_ctrl #(
    .CLK_PER_SEC(CPS),
    .WALK_SEC   (WS),
    .FLASH_SEC  (FS),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .countdown  (countdown),
    .req_pending(req_pending),
    .fault      (fault)
`ifdef PED_BEEP_EN
    ,
    .beep       (beep_got)
`endif
  );

`ifndef PED_BEEP_EN
  assign beep_got = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model: mode plus cycles elapsed since the walk grant
  int   m_mode;
  int   m_e;
  logic m_req;
  logic m_pr;

  task automatic model_step(input logic g, y, r, b, rn);
    int ones;
    ones = int'(g) + int'(y) + int'(r);
    if (!rn) begin
      m_mode = M_IDLE;
      m_e    = 0;
      m_req  = 1'b0;
      m_pr   = 1'b0;
      return;
    end
    if (m_mode == M_FLT || ones != 1) begin
      m_mode = M_FLT;
      m_req  = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (b) m_req = 1'b1;
          if (r && !m_pr && m_req) begin
            m_mode = M_ACT;
            m_e    = 0;
            m_req  = 1'b0;
          end
        end
        M_ACT: begin
          if (b && m_e >= WALK_CYC) m_req = 1'b1;
          if (!r) m_mode = M_CLR;
          else begin
            m_e = m_e + 1;
            if (m_e >= TOT_CYC) m_mode = M_CLR;
          end
        end
        M_CLR: begin
          if (b) m_req = 1'b1;
          if (!r) m_mode = M_IDLE;
        end
        default: ;
      endcase
    end
    m_pr = r;
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.cyc  = 0;
    x.walk = 1'b0;
    x.dw   = 1'b1;
    x.cd   = '0;
    x.req  = m_req;
    x.flt  = (m_mode == M_FLT);
    x.bp   = 1'b0;
    if (m_mode == M_ACT) begin
      if (m_e < WALK_CYC) begin
        x.walk = 1'b1;
        x.dw   = 1'b0;
        x.bp   = (m_e % CPS) < (CPS / 2);
      end else begin
        x.dw = (((m_e - WALK_CYC) / (CPS / 2)) % 2) == 0;
        x.bp = x.dw;
      end
      x.cd = CW'(WS + FS - m_e / CPS);
    end
`ifndef PED_BEEP_EN
    x.bp = 1'b0;
`endif
    return x;
  endfunction

  task automatic step(input logic g, y, r, b, rn);
    exp_t x;
    @(posedge clk);
    #1;
    green   = g;
    yellow  = y;
    red     = r;
    ped_btn = b;
    rstn    = rn;
    model_step(g, y, r, b, rn);
    x     = model_out();
    x.cyc = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic hold(input logic g, y, r, b, input int n,
                      input logic rn = 1'b1);
    for (int i = 0; i < n; i++) step(g, y, r, b, rn);
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      n_cmp++;
      if (walk !== me.walk || dont_walk !== me.dw ||
          countdown !== me.cd || req_pending !== me.req ||
          fault !== me.flt || beep_got !== me.bp) begin
        n_bad++;
        $display("FAIL outs cyc=%0d got w=%b dw=%b cd=%0d rq=%b f=%b bp=%b exp w=%b dw=%b cd=%0d rq=%b f=%b bp=%b",
                 cyc, walk, dont_walk, countdown, req_pending, fault,
                 beep_got, me.walk, me.dw, me.cd, me.req, me.flt, me.bp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bad;
    int gd, yd, rd;
    rstn = 1'b0; green = 1'b0; yellow = 1'b0;
    red = 1'b0; ped_btn = 1'b0;
    m_mode = M_IDLE; m_e = 0; m_req = 1'b0; m_pr = 1'b0;

    hold(0, 0, 0, 0, 3, 1'b0);
    hold(0, 0, 1, 0, 20);
    hold(1, 0, 0, 0, 3); hold(1, 0, 0, 1, 1);
    hold(1, 0, 0, 0, 3); hold(0, 1, 0, 0, 3);
    hold(0, 0, 1, 0, 60);
    hold(1, 0, 0, 0, 4); hold(0, 1, 0, 0, 2);
    hold(0, 0, 1, 0, 8); hold(0, 0, 1, 1, 1);
    hold(0, 0, 1, 0, 6);
    hold(1, 0, 0, 0, 4); hold(0, 1, 0, 0, 2);
    hold(0, 0, 1, 0, 40);
    hold(1, 0, 0, 1, 1); hold(1, 0, 0, 0, 3);
    hold(0, 1, 0, 0, 2);
    hold(0, 0, 1, 0, 13); hold(1, 0, 0, 0, 4);
    hold(1, 0, 1, 0, 1); hold(1, 0, 0, 0, 4);
    hold(0, 1, 0, 0, 2); hold(0, 0, 1, 1, 10);
    hold(0, 0, 1, 0, 2, 1'b0);

    for (int p = 0; p < 40; p++) begin
      gd = $urandom_range(2, 12);
      yd = $urandom_range(1, 5);
      rd = ($urandom_range(0, 1) == 1) ? $urandom_range(52, 70)
                                       : $urandom_range(3, 45);
      for (int i = 0; i < gd; i++)
        step(1, 0, 0, $urandom_range(0, 4) == 0, 1'b1);
      for (int i = 0; i < yd; i++)
        step(0, 1, 0, $urandom_range(0, 4) == 0, 1'b1);
      for (int i = 0; i < rd; i++)
        step(0, 0, 1, $urandom_range(0, 9) == 0, 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        bad = 3'($urandom);
        while ($countones(bad) == 1) bad = 3'($urandom);
        step(bad[2], bad[1], bad[0], 1'b0, 1'b1);
        hold(1, 0, 0, 1, 3);
        hold(0, 0, 1, 0, 3);
        hold(1, 0, 0, 0, 2, 1'b0);
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
